// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: 2-bit bimodal counter states,
// the table entry layout and the saturating counter update.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_cnt_t;

  // Widest tag any PC split can produce (PC[31:2] with a zero-width index).
  localparam int TAG_MAX_W = 30;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
    bp_cnt_t              cnt;
  } bp_entry_t;

  function automatic bp_cnt_t cnt_next(input bp_cnt_t cnt, input logic taken);
    if (taken) return (cnt == ST)  ? ST  : bp_cnt_t'(cnt + 2'd1);
    else       return (cnt == SNT) ? SNT : bp_cnt_t'(cnt - 2'd1);
  endfunction

endpackage

// File: rtl/bp_table.sv
// Direct-mapped BTB/BHT storage: two asynchronous read ports (fetch and
// execute) and one synchronous write port; reset clears valid and counters.
module bp_table
  import bp_pkg::*;
#(
  parameter int         ENTRIES  = 64,
  parameter int         IDX_W    = $clog2(ENTRIES),
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_a_idx,
  output bp_entry_t        rd_a,
  input  logic [IDX_W-1:0] rd_b_idx,
  output bp_entry_t        rd_b,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  bp_entry_t        wr_entry
);

  logic                 valid_q  [ENTRIES];
  bp_cnt_t              cnt_q    [ENTRIES];
  logic [TAG_MAX_W-1:0] tag_q    [ENTRIES];
  logic [31:0]          target_q [ENTRIES];

  // NOTE: only valid and cnt are reset; tag and target stay unreset because an
  // entry with valid=0 never exposes them, so they can map onto plain RAM bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= bp_cnt_t'(CNT_INIT);
      end
    end else if (we) begin
      // NOTE: non-blocking so every reader in this edge sees pre-update contents.
      valid_q[wr_idx] <= wr_entry.valid;
      cnt_q[wr_idx]   <= wr_entry.cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_idx]    <= wr_entry.tag;
      target_q[wr_idx] <= wr_entry.target;
    end
  end

  always_comb begin
    rd_a.valid  = valid_q[rd_a_idx];
    rd_a.tag    = tag_q[rd_a_idx];
    rd_a.target = target_q[rd_a_idx];
    rd_a.cnt    = cnt_q[rd_a_idx];
    rd_b.valid  = valid_q[rd_b_idx];
    rd_b.tag    = tag_q[rd_b_idx];
    rd_b.target = target_q[rd_b_idx];
    rd_b.cnt    = cnt_q[rd_b_idx];
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Bimodal branch predictor with BTB plus EX-stage redirect control.
// Define BP_STATS_EN to add the BrCount/MispredCount statistics outputs.
module branch_predict_ctrl
  import bp_pkg::*;
#(
  parameter int         ENTRIES  = 64,
  parameter int         IDX_W    = $clog2(ENTRIES),
  parameter int         TAG_W    = 10,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        BrValidE,
  input  logic        StallE,
  input  logic [31:0] PCE,
  input  logic        BranchE,
  input  logic [31:0] BranchTarget,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        MispredictE,
  output logic [31:0] RedirectPCE
`ifdef BP_STATS_EN
  ,
  output logic [31:0] BrCount,
  output logic [31:0] MispredCount
`endif
);

  logic [IDX_W-1:0]     idx_f, idx_e;
  logic [TAG_MAX_W-1:0] tag_f, tag_e;
  bp_entry_t            ent_f, ent_e, wr_entry;
  logic                 hit_f, hit_e, upd, we;

  assign idx_f = PCF[IDX_W+1:2];
  assign idx_e = PCE[IDX_W+1:2];
  assign tag_f = TAG_MAX_W'(PCF[IDX_W+TAG_W+1:IDX_W+2]);
  assign tag_e = TAG_MAX_W'(PCE[IDX_W+TAG_W+1:IDX_W+2]);

  bp_table #(
    .ENTRIES  (ENTRIES),
    .IDX_W    (IDX_W),
    .CNT_INIT (CNT_INIT)
  ) u_table (
    .clk      (clk),
    .rst      (rst),
    .rd_a_idx (idx_f),
    .rd_a     (ent_f),
    .rd_b_idx (idx_e),
    .rd_b     (ent_e),
    .we       (we),
    .wr_idx   (idx_e),
    .wr_entry (wr_entry)
  );

  assign hit_f       = ent_f.valid && (ent_f.tag == tag_f);
  assign hit_e       = ent_e.valid && (ent_e.tag == tag_e);
  assign PredTakenF  = hit_f && ent_f.cnt[1];
  assign PredTargetF = hit_f ? ent_f.target : 32'd0;

  assign MispredictE = BrValidE && ((PredTakenE != BranchE) ||
                       (PredTakenE && BranchE && (PredTargetE != BranchTarget)));
  assign RedirectPCE = BranchE ? BranchTarget : PCE + 32'd4;

  assign upd = BrValidE && !StallE;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    we       = 1'b0;
    wr_entry = ent_e;
    if (upd && !rst) begin
      if (hit_e) begin
        we           = 1'b1;
        wr_entry.cnt = cnt_next(ent_e.cnt, BranchE);
        if (BranchE) wr_entry.target = BranchTarget;
      end else if (BranchE) begin
        we       = 1'b1;
        wr_entry = '{valid: 1'b1, tag: tag_e, target: BranchTarget, cnt: WT};
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] br_count_d, br_count_q, mispred_count_d, mispred_count_q;

  always_comb begin
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    if (upd) begin
      if (br_count_q != 32'hFFFF_FFFF) br_count_d = br_count_q + 32'd1;
      if (MispredictE && (mispred_count_q != 32'hFFFF_FFFF))
        mispred_count_d = mispred_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_q      <= 32'd0;
      mispred_count_q <= 32'd0;
    end else begin
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign BrCount      = br_count_q;
  assign MispredCount = mispred_count_q;
`endif

  // PC bits outside the index/tag window do not take part in the lookup.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{PCF[31:IDX_W+TAG_W+2], PCF[1:0]};

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: an abstract table model compared
// every cycle, plus directed vectors with hand-computed expectations.
module tb_branch_predict_ctrl;

  localparam int ENTRIES = 64;
  localparam int IDX_W   = 6;
  localparam int TAG_W   = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        BrValidE, StallE, BranchE, PredTakenE;
  logic [31:0] PCE, BranchTarget, PredTargetE;
  logic        MispredictE;
  logic [31:0] RedirectPCE;
`ifdef BP_STATS_EN
  logic [31:0] BrCount, MispredCount;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  branch_predict_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .PCF          (PCF),
    .PredTakenF   (PredTakenF),
    .PredTargetF  (PredTargetF),
    .BrValidE     (BrValidE),
    .StallE       (StallE),
    .PCE          (PCE),
    .BranchE      (BranchE),
    .BranchTarget (BranchTarget),
    .PredTakenE   (PredTakenE),
    .PredTargetE  (PredTargetE),
    .MispredictE  (MispredictE),
    .RedirectPCE  (RedirectPCE)
`ifdef BP_STATS_EN
    ,
    .BrCount      (BrCount),
    .MispredCount (MispredCount)
`endif
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: a table of plain integers, counters as 0..3.
  bit          m_ready = 1'b0;
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_cnt    [ENTRIES];
  longint      m_br = 0, m_mis = 0;

  function automatic int pc_idx(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic int unsigned pc_tag(input logic [31:0] pc);
    return (pc >> (2 + IDX_W)) % (1 << TAG_W);
  endfunction

  function automatic bit exp_mispredict();
    return BrValidE && ((PredTakenE != BranchE) ||
                        (PredTakenE && BranchE && PredTargetE != BranchTarget));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] = 1'b0;
        m_cnt[i]   = 1;
      end
      m_br    = 0;
      m_mis   = 0;
      m_ready = 1'b1;
    end else if (BrValidE && !StallE) begin
      int i;
      i = pc_idx(PCE);
      if (m_br < 64'hFFFF_FFFF) m_br++;
      if (exp_mispredict() && m_mis < 64'hFFFF_FFFF) m_mis++;
      if (m_valid[i] && m_tag[i] == pc_tag(PCE)) begin
        m_cnt[i] = BranchE ? ((m_cnt[i] + 1 > 3) ? 3 : m_cnt[i] + 1)
                           : ((m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1);
        if (BranchE) m_target[i] = BranchTarget;
      end else if (BranchE) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = pc_tag(PCE);
        m_target[i] = BranchTarget;
        m_cnt[i]    = 2;
      end
    end
  end

  // Compare process: mid-cycle, inputs are stable and the model is current.
  always @(negedge clk) begin
    if (m_ready && !rst) begin
      int  i;
      bit  hit;
      i   = pc_idx(PCF);
      hit = m_valid[i] && m_tag[i] == pc_tag(PCF);
      check("model_PredTakenF", 32'(PredTakenF), 32'(hit && m_cnt[i] >= 2));
      check("model_PredTargetF", PredTargetF, hit ? m_target[i] : 32'd0);
      check("model_MispredictE", 32'(MispredictE), 32'(exp_mispredict()));
      check("model_RedirectPCE", RedirectPCE, BranchE ? BranchTarget : PCE + 32'd4);
`ifdef BP_STATS_EN
      check("model_BrCount", BrCount, 32'(m_br));
      check("model_MispredCount", MispredCount, 32'(m_mis));
`endif
    end
  end

  // Inputs change 1 time unit after the rising edge.
  task automatic drive(input logic r, input logic [31:0] pcf, input logic brv,
                       input logic stall, input logic [31:0] pce, input logic br,
                       input logic [31:0] bt, input logic pt, input logic [31:0] ptg);
    @(posedge clk);
    #1;
    rst = r; PCF = pcf; BrValidE = brv; StallE = stall; PCE = pce;
    BranchE = br; BranchTarget = bt; PredTakenE = pt; PredTargetE = ptg;
    #5;
  endtask

  task automatic idle(input logic [31:0] pcf);
    drive(1'b0, pcf, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; PCF = '0; BrValidE = 1'b0; StallE = 1'b0; PCE = '0;
    BranchE = 1'b0; BranchTarget = '0; PredTakenE = 1'b0; PredTargetE = '0;
    drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Reset state
    idle(32'h100);
    check("reset_PredTakenF", 32'(PredTakenF), 32'd0);
    check("reset_PredTargetF", PredTargetF, 32'd0);

    // Miss, taken: allocate as WT
    drive(1'b0, 32'h100, 1'b1, 1'b0, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    check("alloc_MispredictE", 32'(MispredictE), 32'd1);
    check("alloc_RedirectPCE", RedirectPCE, 32'h200);
    check("alloc_same_cycle_PredTakenF", 32'(PredTakenF), 32'd0);
    idle(32'h100);
    check("alloc_PredTakenF", 32'(PredTakenF), 32'd1);
    check("alloc_PredTargetF", PredTargetF, 32'h200);

    // Two not-taken resolves: WT -> WNT -> SNT
    drive(1'b0, 32'h100, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
    check("nt1_MispredictE", 32'(MispredictE), 32'd1);
    check("nt1_RedirectPCE", RedirectPCE, 32'h104);
    drive(1'b0, 32'h100, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    check("nt2_PredTakenF", 32'(PredTakenF), 32'd0);
    check("nt2_MispredictE", 32'(MispredictE), 32'd0);

    // Taken with wrong target: retarget to 0x300, SNT -> WNT
    drive(1'b0, 32'h100, 1'b1, 1'b0, 32'h100, 1'b1, 32'h300, 1'b1, 32'h200);
    check("retarget_MispredictE", 32'(MispredictE), 32'd1);
    check("retarget_RedirectPCE", RedirectPCE, 32'h300);
    idle(32'h100);
    check("retarget_PredTargetF", PredTargetF, 32'h300);
    check("retarget_PredTakenF", 32'(PredTakenF), 32'd0);

    // Aliasing: 0x200 shares idx 0 with 0x100 under a different tag
    drive(1'b0, 32'h100, 1'b1, 1'b0, 32'h100 + 4 * ENTRIES, 1'b1, 32'h400, 1'b0, 32'h0);
    check("alias_same_cycle_PredTargetF", PredTargetF, 32'h300);
    idle(32'h100);
    check("alias_old_PredTargetF", PredTargetF, 32'h0);
    check("alias_old_PredTakenF", 32'(PredTakenF), 32'd0);
    idle(32'h200);
    check("alias_new_PredTakenF", 32'(PredTakenF), 32'd1);
    check("alias_new_PredTargetF", PredTargetF, 32'h400);

    // Stall for 3 cycles, then release: exactly one step WT -> WNT
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 32'h200, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h400);
      check("stall_PredTakenF", 32'(PredTakenF), 32'd1);
      check("stall_MispredictE", 32'(MispredictE), 32'd1);
      check("stall_RedirectPCE", RedirectPCE, 32'h204);
    end
    drive(1'b0, 32'h200, 1'b1, 1'b0, 32'h200, 1'b0, 32'h0, 1'b1, 32'h400);
    idle(32'h200);
    check("stall_after_PredTakenF", 32'(PredTakenF), 32'd0);
    drive(1'b0, 32'h200, 1'b1, 1'b0, 32'h200, 1'b1, 32'h400, 1'b0, 32'h0);
    idle(32'h200);
    check("stall_one_step_PredTakenF", 32'(PredTakenF), 32'd1);
`ifdef BP_STATS_EN
    check("stats_BrCount", BrCount, 32'd7);
    check("stats_MispredCount", MispredCount, 32'd6);
`endif

    // Reset together with an update: reset wins
    drive(1'b1, 32'h300, 1'b1, 1'b0, 32'h300, 1'b1, 32'h500, 1'b0, 32'h0);
    idle(32'h300);
    check("rst_upd_PredTakenF", 32'(PredTakenF), 32'd0);
    check("rst_upd_PredTargetF", PredTargetF, 32'd0);
    idle(32'h200);
    check("rst_clear_PredTakenF", 32'(PredTakenF), 32'd0);

    // Fall-through redirect wraps around at the top of the address space
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
    check("wrap_RedirectPCE", RedirectPCE, 32'h0);
    check("wrap_MispredictE", 32'(MispredictE), 32'd0);
    idle(32'hFFFF_FFFC);
    check("wrap_no_alloc_PredTakenF", 32'(PredTakenF), 32'd0);
    idle(32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
